// File: rtl/coreabc_fetch_pkg.sv
// coreabc_fetch_pkg: shared types and widths for the CoreABC instruction fetch stage.
//   state_e          fetch FSM states (IDLE, FETCH, HOLD)
//   ADDR_W           program RAM address width
//   BYTE_W           program RAM data width
//   MAX_INSTR_BYTES  largest supported instruction length in bytes
package coreabc_fetch_pkg;
    localparam int ADDR_W = 8;
    localparam int BYTE_W = 8;
    localparam int MAX_INSTR_BYTES = 4;
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_e;
endpackage

// File: rtl/coreabc_instr_fetch_if.sv
// coreabc_instr_fetch_if: control, RAM read port and decoder handshake of the fetch stage.
//   master  sequencer/RAM/decoder side: drives start/jump/halt, ram_rd, instr_ready
//   slave   fetch stage side: drives ram_ren/ram_raddr, instr_valid/data/addr, busy
interface coreabc_instr_fetch_if #(
    parameter int INSTR_BYTES = 3
);
    import coreabc_fetch_pkg::*;
    logic                          start;
    logic [ADDR_W-1:0]             start_addr;
    logic                          jump;
    logic [ADDR_W-1:0]             jump_addr;
    logic                          halt;
    logic                          ram_ren;
    logic [ADDR_W-1:0]             ram_raddr;
    logic [BYTE_W-1:0]             ram_rd;
    logic                          instr_valid;
    logic                          instr_ready;
    logic [BYTE_W*INSTR_BYTES-1:0] instr_data;
    logic [ADDR_W-1:0]             instr_addr;
    logic                          busy;
    modport master (
        output start, start_addr, jump, jump_addr, halt, ram_rd, instr_ready,
        input  ram_ren, ram_raddr, instr_valid, instr_data, instr_addr, busy
    );
    modport slave (
        input  start, start_addr, jump, jump_addr, halt, ram_rd, instr_ready,
        output ram_ren, ram_raddr, instr_valid, instr_data, instr_addr, busy
    );
endinterface

// File: rtl/coreabc_fetch_buf.sv
// coreabc_fetch_buf: one instruction word register with valid flag; load wins over clear.
//   clk, rst_n        clock, asynchronous active-low reset
//   load_i            capture data_i/addr_i and set valid
//   clr_i             drop the word (valid, data and address return to zero)
//   valid_o/data_o/addr_o  buffered word and the address of its first byte
module coreabc_fetch_buf
    import coreabc_fetch_pkg::*;
#(
    parameter int W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              clr_i,
    input  logic [W-1:0]      data_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              valid_o,
    output logic [W-1:0]      data_o,
    output logic [ADDR_W-1:0] addr_o
);
    logic              valid_q, valid_d;
    logic [W-1:0]      data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        valid_d = load_i ? 1'b1   : clr_i ? 1'b0 : valid_q;
        data_d  = load_i ? data_i : clr_i ? '0   : data_q;
        addr_d  = load_i ? addr_i : clr_i ? '0   : addr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign addr_o  = addr_q;
endmodule

// File: rtl/coreabc_instr_fetch.sv
// coreabc_instr_fetch: reads the 256x8 program RAM one byte per cycle and assembles
// INSTR_BYTES-byte instruction words (lowest address in the low byte) for the decoder.
//   PCLK, PRESETN  clock, asynchronous active-low reset
//   bus (slave)    start/jump/halt control, RAM read port, valid/ready word output, busy
// Build option COREABC_FETCH_PREFETCH_EN: second word buffer so fetching continues while
// a word waits for the decoder; undefined gives a single buffer and fetch stalls in HOLD.
module coreabc_instr_fetch
    import coreabc_fetch_pkg::*;
#(
    parameter int INSTR_BYTES = 3
) (
    input  logic PCLK,
    input  logic PRESETN,
    coreabc_instr_fetch_if.slave bus
);
    localparam int W = BYTE_W * INSTR_BYTES;
    localparam logic [2:0] N = 3'(INSTR_BYTES);
`ifdef COREABC_FETCH_PREFETCH_EN
    localparam logic [2:0] CAP = 3'd2;
`else
    localparam logic [2:0] CAP = 3'd1;
`endif

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              rd_pend_q, rd_pend_d;
    logic [2:0]        rd_idx_q, rd_idx_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [W-1:0]      asm_q, asm_d;

    logic              active, flush, ren, pop, land, issue_last, start_next, shift;
    logic              b0_load, b0_clr, b0_v, b1_v;
    logic [W-1:0]      b0_data, b1_data, land_data;
    logic [ADDR_W-1:0] b0_addr, b1_addr, land_addr;
    logic [2:0]        occ;

    always_comb begin
        active     = state_q != IDLE;
        flush      = active & (bus.halt | bus.jump);
        ren        = active & (cnt_q < N);
        issue_last = ren & (cnt_q == N - 3'd1);
        pop        = b0_v & bus.instr_ready & ~flush;
        land       = rd_pend_q & (rd_idx_q == N - 3'd1) & ~flush;
        land_data  = asm_q;
        land_data[BYTE_W*(INSTR_BYTES-1) +: BYTE_W] = bus.ram_rd;
        land_addr  = rd_addr_q - ADDR_W'(INSTR_BYTES - 1);
        shift      = pop & b1_v;
        b0_load    = shift | (land & (~b0_v | pop));
        b0_clr     = flush | pop;
        // Words that will occupy buffers after this edge, counting the one still being
        // issued; a new word may only start if it too will find a free buffer.
        occ        = 3'(b0_v) + 3'(b1_v) - 3'(pop) + 3'(issue_last) + 3'(land);
        start_next = active & ~flush & (issue_last | (cnt_q == N)) & (occ < CAP);
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        rd_pend_d  = ren & ~flush;
        rd_idx_d   = cnt_q;
        rd_addr_d  = addr_q;
        asm_d      = asm_q;
        if (rd_pend_q & ~flush)
            asm_d[BYTE_W*int'(rd_idx_q) +: BYTE_W] = bus.ram_rd;
        if (ren & ~flush) begin
            addr_d = addr_q + 1'b1;
            cnt_d  = cnt_q + 1'b1;
        end
        if (start_next)
            cnt_d = '0;
        if (!active & bus.start & ~bus.halt) begin
            addr_d = bus.start_addr;
            cnt_d  = '0;
        end else if (active & ~bus.halt & bus.jump) begin
            addr_d = bus.jump_addr;
            cnt_d  = '0;
        end
        state_d = !active  ? ((bus.start & ~bus.halt) ? FETCH : IDLE) :
                  bus.halt ? IDLE :
                  bus.jump ? FETCH :
                  (b0_load | (b0_v & ~b0_clr)) ? HOLD : FETCH;
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            rd_pend_q <= 1'b0;
            rd_idx_q  <= '0;
            rd_addr_q <= '0;
            asm_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= rd_pend_d;
            rd_idx_q  <= rd_idx_d;
            rd_addr_q <= rd_addr_d;
            asm_q     <= asm_d;
        end
    end

    coreabc_fetch_buf #(.W(W)) u_buf0 (
        .clk(PCLK), .rst_n(PRESETN), .load_i(b0_load), .clr_i(b0_clr),
        .data_i(shift ? b1_data : land_data), .addr_i(shift ? b1_addr : land_addr),
        .valid_o(b0_v), .data_o(b0_data), .addr_o(b0_addr)
    );

`ifdef COREABC_FETCH_PREFETCH_EN
    // A landing word goes to the second buffer when the first stays occupied,
    // or when the second buffer is moving forward into the first this edge.
    coreabc_fetch_buf #(.W(W)) u_buf1 (
        .clk(PCLK), .rst_n(PRESETN), .load_i(land & b0_v & (~pop | b1_v)), .clr_i(flush | shift),
        .data_i(land_data), .addr_i(land_addr),
        .valid_o(b1_v), .data_o(b1_data), .addr_o(b1_addr)
    );
`else
    assign b1_v    = 1'b0;
    assign b1_data = '0;
    assign b1_addr = '0;
`endif

    assign bus.ram_ren     = ren;
    assign bus.ram_raddr   = addr_q;
    assign bus.instr_valid = b0_v;
    assign bus.instr_data  = b0_data;
    assign bus.instr_addr  = b0_addr;
    assign bus.busy        = active;
endmodule

// File: tb/tb_coreabc_instr_fetch.sv
// tb_coreabc_instr_fetch: directed self-checking bench for coreabc_instr_fetch (base build).
module tb_coreabc_instr_fetch;
    logic PCLK = 1'b0;
    logic PRESETN = 1'b0;
    logic [7:0] mem [256];
    logic [63:0] act, exp;
    int vectors = 0;
    int miscompares = 0;

    always #5 PCLK = ~PCLK;

    coreabc_instr_fetch_if #(.INSTR_BYTES(3)) bus ();
    coreabc_instr_fetch #(.INSTR_BYTES(3)) dut (.PCLK(PCLK), .PRESETN(PRESETN), .bus(bus));

    always @(posedge PCLK) if (bus.ram_ren) bus.ram_rd <= mem[bus.ram_raddr];

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    task automatic pulse_start(input logic [7:0] a);
        bus.start_addr = a;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic do_halt();
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
    endtask

    task automatic test_reset();
        PRESETN = 1'b0;
        tick(2);
        act = 64'({bus.ram_ren, bus.ram_raddr, bus.instr_valid, bus.instr_data, bus.instr_addr, bus.busy});
        vectors++; if (act !== 64'd0) begin miscompares++; $display("FAIL rst_initial got=%h exp=%h", act, 64'd0); end
        PRESETN = 1'b1;
        tick();
        pulse_start(8'h10);
        tick(2);
        #2 PRESETN = 1'b0;
        #1;
        act = 64'({bus.ram_ren, bus.ram_raddr, bus.instr_valid, bus.instr_data, bus.instr_addr, bus.busy});
        vectors++; if (act !== 64'd0) begin miscompares++; $display("FAIL rst_midfetch got=%h exp=%h", act, 64'd0); end
        #2 PRESETN = 1'b1;
        tick(4);
        act = 64'({bus.instr_valid, bus.busy, bus.ram_ren});
        vectors++; if (act !== 64'd0) begin miscompares++; $display("FAIL rst_nopartial got=%h exp=%h", act, 64'd0); end
    endtask

    task automatic test_basic();
        pulse_start(8'h10);
        for (int k = 0; k < 3; k++) begin
            act = 64'({bus.ram_ren, bus.ram_raddr});
            exp = 64'({1'b1, 8'(8'h10 + k)});
            vectors++; if (act !== exp) begin miscompares++; $display("FAIL basic_raddr%0d got=%h exp=%h", k, act, exp); end
            tick();
        end
        act = 64'({bus.ram_ren, bus.instr_valid});
        vectors++; if (act !== 64'd0) begin miscompares++; $display("FAIL basic_gap got=%h exp=%h", act, 64'd0); end
        tick();
        act = 64'({bus.instr_valid, bus.instr_data, bus.instr_addr});
        exp = 64'({1'b1, 24'hCCBBAA, 8'h10});
        vectors++; if (act !== exp) begin miscompares++; $display("FAIL basic_word got=%h exp=%h", act, exp); end
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 5; k++) begin
            tick();
            act = 64'({bus.instr_valid, bus.instr_data, bus.instr_addr, bus.ram_ren});
            exp = 64'({1'b1, 24'hCCBBAA, 8'h10, 1'b0});
            vectors++; if (act !== exp) begin miscompares++; $display("FAIL bp_hold%0d got=%h exp=%h", k, act, exp); end
        end
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        act = 64'({bus.instr_valid, bus.ram_ren, bus.ram_raddr});
        exp = 64'({1'b0, 1'b1, 8'h13});
        vectors++; if (act !== exp) begin miscompares++; $display("FAIL bp_next_raddr got=%h exp=%h", act, exp); end
        tick(4);
        act = 64'({bus.instr_valid, bus.instr_data, bus.instr_addr});
        exp = 64'({1'b1, 24'h332211, 8'h13});
        vectors++; if (act !== exp) begin miscompares++; $display("FAIL bp_next_word got=%h exp=%h", act, exp); end
        do_halt();
        act = 64'({bus.busy, bus.instr_valid});
        vectors++; if (act !== 64'd0) begin miscompares++; $display("FAIL bp_halt got=%h exp=%h", act, 64'd0); end
    endtask

    task automatic test_wrap();
        logic [7:0] ea [3];
        ea[0] = 8'hFE; ea[1] = 8'hFF; ea[2] = 8'h00;
        pulse_start(8'hFE);
        for (int k = 0; k < 3; k++) begin
            act = 64'(bus.ram_raddr);
            exp = 64'(ea[k]);
            vectors++; if (act !== exp) begin miscompares++; $display("FAIL wrap_raddr%0d got=%h exp=%h", k, act, exp); end
            tick();
        end
        tick();
        act = 64'({bus.instr_valid, bus.instr_data, bus.instr_addr});
        exp = 64'({1'b1, 24'h030201, 8'hFE});
        vectors++; if (act !== exp) begin miscompares++; $display("FAIL wrap_word got=%h exp=%h", act, exp); end
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        tick(4);
        act = 64'({bus.instr_valid, bus.instr_data, bus.instr_addr});
        exp = 64'({1'b1, 24'h665544, 8'h01});
        vectors++; if (act !== exp) begin miscompares++; $display("FAIL wrap_next got=%h exp=%h", act, exp); end
        do_halt();
    endtask

    task automatic test_jump();
        pulse_start(8'h20);
        tick();
        bus.jump_addr = 8'h40;
        bus.jump = 1'b1;
        tick();
        bus.jump = 1'b0;
        act = 64'({bus.ram_ren, bus.ram_raddr, bus.instr_valid});
        exp = 64'({1'b1, 8'h40, 1'b0});
        vectors++; if (act !== exp) begin miscompares++; $display("FAIL jump_redirect got=%h exp=%h", act, exp); end
        for (int k = 0; k < 3; k++) begin
            tick();
            act = 64'(bus.instr_valid);
            vectors++; if (act !== 64'd0) begin miscompares++; $display("FAIL jump_novalid%0d got=%h exp=%h", k, act, 64'd0); end
        end
        tick();
        act = 64'({bus.instr_valid, bus.instr_data, bus.instr_addr});
        exp = 64'({1'b1, 24'hD3D2D1, 8'h40});
        vectors++; if (act !== exp) begin miscompares++; $display("FAIL jump_word got=%h exp=%h", act, exp); end
        bus.instr_ready = 1'b1;
        bus.jump_addr = 8'h60;
        bus.jump = 1'b1;
        tick();
        bus.jump = 1'b0;
        bus.instr_ready = 1'b0;
        act = 64'({bus.instr_valid, bus.ram_ren, bus.ram_raddr});
        exp = 64'({1'b0, 1'b1, 8'h60});
        vectors++; if (act !== exp) begin miscompares++; $display("FAIL jump_hold_drop got=%h exp=%h", act, exp); end
        tick(3);
        act = 64'(bus.instr_valid);
        vectors++; if (act !== 64'd0) begin miscompares++; $display("FAIL jump_hold_gap got=%h exp=%h", act, 64'd0); end
        tick();
        act = 64'({bus.instr_valid, bus.instr_data, bus.instr_addr});
        exp = 64'({1'b1, 24'hE3E2E1, 8'h60});
        vectors++; if (act !== exp) begin miscompares++; $display("FAIL jump_hold_word got=%h exp=%h", act, exp); end
        do_halt();
    endtask

    task automatic test_halt_jump();
        pulse_start(8'h30);
        bus.start_addr = 8'h80;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        act = 64'({bus.busy, bus.ram_raddr});
        exp = 64'({1'b1, 8'h32});
        vectors++; if (act !== exp) begin miscompares++; $display("FAIL start_busy_ignored got=%h exp=%h", act, exp); end
        bus.halt = 1'b1;
        bus.jump = 1'b1;
        bus.jump_addr = 8'h50;
        tick();
        bus.halt = 1'b0;
        bus.jump = 1'b0;
        act = 64'({bus.busy, bus.instr_valid, bus.ram_ren});
        vectors++; if (act !== 64'd0) begin miscompares++; $display("FAIL halt_jump got=%h exp=%h", act, 64'd0); end
        tick();
        act = 64'({bus.busy, bus.ram_ren});
        vectors++; if (act !== 64'd0) begin miscompares++; $display("FAIL halt_jump_idle got=%h exp=%h", act, 64'd0); end
        bus.start_addr = 8'h10;
        bus.start = 1'b1;
        bus.halt = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.halt = 1'b0;
        act = 64'({bus.busy, bus.ram_ren});
        vectors++; if (act !== 64'd0) begin miscompares++; $display("FAIL start_halt_idle got=%h exp=%h", act, 64'd0); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'hAA; mem[8'h11] = 8'hBB; mem[8'h12] = 8'hCC;
        mem[8'h13] = 8'h11; mem[8'h14] = 8'h22; mem[8'h15] = 8'h33;
        mem[8'hFE] = 8'h01; mem[8'hFF] = 8'h02; mem[8'h00] = 8'h03;
        mem[8'h01] = 8'h44; mem[8'h02] = 8'h55; mem[8'h03] = 8'h66;
        mem[8'h20] = 8'h71; mem[8'h21] = 8'h72; mem[8'h22] = 8'h73;
        mem[8'h40] = 8'hD1; mem[8'h41] = 8'hD2; mem[8'h42] = 8'hD3;
        mem[8'h60] = 8'hE1; mem[8'h61] = 8'hE2; mem[8'h62] = 8'hE3;
        bus.start = 1'b0;
        bus.start_addr = 8'h00;
        bus.jump = 1'b0;
        bus.jump_addr = 8'h00;
        bus.halt = 1'b0;
        bus.instr_ready = 1'b0;
        bus.ram_rd = 8'h00;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_jump();
        test_halt_jump();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
